line_cube: RTL and testbench

- Hardware Bresenham line rasteriser for the display pipeline.
- On `start`, it walks from (x0,y0) to (x1,y1) inclusive and emits one pixel coordinate per clock with a `plot` strobe.
- It raises `done` when the final pixel has been emitted.
- Downstream pixel writers consume x/y while `plot`=1.

---
 rtl/line_pkg.sv | 27 ++
 rtl/line_cube.sv | 155 +++++++++++++++
 tb/tb_line_cube.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
// Shared definitions for the Bresenham line rasteriser.
//   - default coordinate / counter widths
//   - FSM state encoding
//   - signed error-term type wide enough for full-range endpoints
//   - absolute-difference helper used when a line is launched
package line_pkg;

  localparam int LINE_XW = 11;
  localparam int LINE_YW = 10;
  localparam int LINE_CW = 12;
  // One sign bit, one bit for 2*err, one bit of headroom over the widest axis.
  localparam int LINE_EW = ((LINE_XW > LINE_YW) ? LINE_XW : LINE_YW) + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } line_state_t;

  typedef logic signed [LINE_EW-1:0] err_t;

  // |a - b| for unsigned operands.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_cube.sv
// line_cube: Bresenham line rasteriser.
// Walks from (x0,y0) to (x1,y1) inclusive, one pixel per clock, with plot=1
// while x/y hold a valid pixel, then raises done.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start    launch request, sampled in IDLE
//   x0,y0    start point (unsigned)
//   x1,y1    end point (unsigned)
//   x,y      current pixel (registered)
//   x_count  pixels emitted so far in the current line
//   done     line complete (held until start drops)
//   plot     x/y valid this cycle
module line_cube
  import line_pkg::*;
#(
  parameter int XW = LINE_XW,
  parameter int YW = LINE_YW,
  parameter int CW = LINE_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] x_count,
  output logic          done,
  output logic          plot
);

  localparam int EW = ((XW > YW) ? XW : YW) + 3;

  line_state_t state_reg, state_next;

  logic [XW-1:0]        x_reg, x_next, xe_reg;
  logic [YW-1:0]        y_reg, y_next, ye_reg;
  logic [CW-1:0]        count_reg;
  logic signed [EW-1:0] dx_reg, dy_reg, err_reg, err_next;
  logic                 sx_neg_reg, sy_neg_reg;

  // Launch-time values.
  logic signed [EW-1:0] dx_load, dy_load;

  // Per-step decision terms.
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic                 step_x, step_y, at_end;

  assign dx_load = signed'(EW'(abs_diff(32'(x1), 32'(x0))));
  assign dy_load = -signed'(EW'(abs_diff(32'(y1), 32'(y0))));

  assign at_end = (x_reg == xe_reg) && (y_reg == ye_reg);

  // e2 = 2*err carries one extra bit so the doubling can never wrap.
  assign e2     = {err_reg, 1'b0};
  assign dx_ext = {dx_reg[EW-1], dx_reg};
  assign dy_ext = {dy_reg[EW-1], dy_reg};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);

  // Next pixel and error; both axes may step in the same cycle, in which
  // case err absorbs both increments.
  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    err_next = err_reg;
    if (step_x) begin
      err_next = err_next + dy_reg;
      x_next   = sx_neg_reg ? (x_reg - XW'(1)) : (x_reg + XW'(1));
    end
    if (step_y) begin
      err_next = err_next + dx_reg;
      y_next   = sy_neg_reg ? (y_reg - YW'(1)) : (y_reg + YW'(1));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = DRAW;
      DRAW:    if (at_end) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    plot = 1'b0;
    done = 1'b0;
    case (state_reg)
      DRAW:    plot = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg      <= '0;
      y_reg      <= '0;
      xe_reg     <= '0;
      ye_reg     <= '0;
      count_reg  <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      err_reg    <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg      <= x0;
            y_reg      <= y0;
            xe_reg     <= x1;
            ye_reg     <= y1;
            dx_reg     <= dx_load;
            dy_reg     <= dy_load;
            err_reg    <= dx_load + dy_load;
            sx_neg_reg <= (x1 < x0);
            sy_neg_reg <= (y1 < y0);
            count_reg  <= '0;
          end
        end
        DRAW: begin
          count_reg <= count_reg + CW'(1);
          // The final pixel is held so x/y read back the end point in DONE.
          if (!at_end) begin
            x_reg   <= x_next;
            y_reg   <= y_next;
            err_reg <= err_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign x_count = count_reg;

endmodule

// File: tb/tb_line_cube.sv
module tb_line_cube;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] x_count;
  logic          done, plot;

  typedef struct { int px; int py; } pix_t;
  pix_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int plot_seen = 0;
  int line_id = 0;

  line_cube #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x(x), .y(y), .x_count(x_count), .done(done), .plot(plot)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: textbook integer Bresenham producing the full pixel list.
  task automatic model_line(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, cx, cy;
    dx = iabs(bx - ax);
    dy = -iabs(by - ay);
    sx = (bx >= ax) ? 1 : -1;
    sy = (by >= ay) ? 1 : -1;
    err = dx + dy;
    cx = ax;
    cy = ay;
    forever begin
      exp_q.push_back('{cx, cy});
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every plot cycle pops one expected pixel.
  always @(negedge clk) begin
    if (plot) begin
      plot_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL extra_plot: got (%0d,%0d), expected no pixel", x, y);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (x != e.px || y != e.py) begin
          fails++;
          $display("[TB] FAIL pixel line %0d: got (%0d,%0d), expected (%0d,%0d)",
                   line_id, x, y, e.px, e.py);
        end
      end
    end
  end

  // Launch a line, scramble the inputs during the draw, wait for done, check.
  task automatic draw_line(input int ax, input int ay, input int bx, input int by,
                           input bit hold_start);
    int n;
    bit got_done;
    line_id++;
    n = ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1;
    plot_seen = 0;
    model_line(ax, ay, bx, by);
    @(negedge clk);
    x0 = XW'(ax); y0 = YW'(ay); x1 = XW'(bx); y1 = YW'(by);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    x0 = XW'($urandom); y0 = YW'($urandom); x1 = XW'($urandom); y1 = YW'($urandom);
    got_done = 0;
    for (int i = 0; i < n + 10; i++) begin
      if (done) begin got_done = 1; break; end
      @(negedge clk);
    end
    check("done_seen", got_done, 1);
    check("plot_cycles", plot_seen, n);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check("x_count", x_count, n);
    check("final_x", x, bx);
    check("final_y", y, by);
    if (hold_start) begin
      repeat (3) @(negedge clk);
      check("done_held", done, 1);
      check("no_redraw", plot_seen, n);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_clear", done, 0);
    $display("[TB] line %0d (%0d,%0d)->(%0d,%0d) pixels=%0d", line_id, ax, ay, bx, by, plot_seen);
  endtask

  initial begin
    bit ok;
    // Reset held for 50 ns, outputs must stay at zero.
    for (int i = 0; i < 4; i++) begin
      #12;
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_count", x_count, 0);
      check("rst_done", done, 0);
      check("rst_plot", plot, 0);
    end
    #2 reset = 1'b1;

    draw_line(0, 0, 300, 525, 1'b1);   // steep, held start
    draw_line(0, 0, 5, 0, 1'b0);       // horizontal
    draw_line(20, 15, 17, 12, 1'b0);   // reverse diagonal
    draw_line(10, 10, 10, 10, 1'b0);   // degenerate
    draw_line(2047, 0, 0, 1023, 1'b0); // full range

    for (int k = 0; k < 14; k++) begin
      if (k < 10)
        draw_line($urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 63), $urandom_range(0, 63), k[0]);
      else
        draw_line($urandom_range(0, 2047), $urandom_range(0, 1023),
                  $urandom_range(0, 2047), $urandom_range(0, 1023), 1'b0);
    end

    // Abort mid-draw.
    line_id++;
    plot_seen = 0;
    model_line(0, 0, 100, 40);
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 100; y1 = 40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (plot_seen >= 20) begin ok = 1; break; end
      @(negedge clk);
    end
    check("abort_reach20", ok, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_x", x, 0);
    check("abort_y", y, 0);
    check("abort_count", x_count, 0);
    check("abort_plot", plot, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_plot_held", plot, 0);
    reset = 1'b1;
    $display("[TB] line %0d aborted after %0d pixels", line_id, plot_seen);
    draw_line(0, 0, 3, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
